// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared FSM encoding and default WS2812 timing for the LED strip controller
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_LATCH = 2'd3
   } led_state_e;

   localparam int DEF_N_LEDS     = 64;
   localparam int DEF_T0H        = 10;
   localparam int DEF_T1H        = 20;
   localparam int DEF_TBIT       = 31;
   localparam int DEF_TRES       = 1250;
   localparam int BITS_PER_PIXEL = 24;

endpackage

// File: rtl/ws2812_bit_timer.sv
// rtl/ws2812_bit_timer.sv - per-bit cycle counter with high/low compare for one WS2812 bit slot
module ws2812_bit_timer
   import led_pkg::*;
#(
   parameter int T0H  = DEF_T0H,
   parameter int T1H  = DEF_T1H,
   parameter int TBIT = DEF_TBIT
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic bit_val,
   output logic high,
   output logic first_cycle,
   output logic last_cycle
);

   localparam int CW = $clog2(TBIT);
   localparam logic [CW-1:0] T0H_C   = CW'(T0H);
   localparam logic [CW-1:0] T1H_C   = CW'(T1H);
   localparam logic [CW-1:0] TLAST_C = CW'(TBIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign first_cycle = en && (cnt_q == '0);
   assign last_cycle  = en && (cnt_q == TLAST_C);
   assign high        = en && (cnt_q < (bit_val ? T1H_C : T0H_C));

   // The counter free-runs across bit and pixel boundaries while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (!en || last_cycle) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_strip_controller.sv
// rtl/led_strip_controller.sv - WS2812 frame engine: fetches GRB pixels and serialises them with reset latch
module led_strip_controller
   import led_pkg::*;
#(
   parameter int N_LEDS = DEF_N_LEDS,
   parameter int T0H    = DEF_T0H,
   parameter int T1H    = DEF_T1H,
   parameter int TBIT   = DEF_TBIT,
   parameter int TRES   = DEF_TRES
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      pix_rd,
   output logic [$clog2(N_LEDS)-1:0] pix_addr,
   input  logic [23:0]               pix_data,
   output logic                      dout
);

   localparam int AW = $clog2(N_LEDS);
   localparam int LW = $clog2(TRES + 1);
   localparam logic [AW-1:0] LAST_PIX   = AW'(N_LEDS - 1);
   localparam logic [LW-1:0] LAST_LATCH = LW'(TRES - 1);
   localparam logic [4:0]    LAST_BIT   = 5'(BITS_PER_PIXEL - 1);

   led_state_e    state_q, state_d;
   logic          fetch_wait_q, fetch_wait_d;
   logic          prefetch_pend_q, prefetch_pend_d;
   logic          done_q, done_d;
   logic [23:0]   shift_q, shift_d;
   logic [23:0]   hold_q, hold_d;
   logic [4:0]    bit_q, bit_d;
   logic [AW-1:0] pix_idx_q, pix_idx_d;
   logic [LW-1:0] latch_cnt_q, latch_cnt_d;

   logic tmr_high, tmr_first, tmr_last, last_pix;

   ws2812_bit_timer #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT)
   ) u_bit_timer (
      .clk         (clk),
      .rstn        (rstn),
      .en          (state_q == ST_SEND),
      .bit_val     (shift_q[23]),
      .high        (tmr_high),
      .first_cycle (tmr_first),
      .last_cycle  (tmr_last)
   );

   assign last_pix = (pix_idx_q == LAST_PIX);
   assign dout     = tmr_high;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

   always_comb begin
      state_d         = state_q;
      fetch_wait_d    = fetch_wait_q;
      prefetch_pend_d = 1'b0;
      done_d          = 1'b0;
      shift_d         = shift_q;
      hold_d          = hold_q;
      bit_d           = bit_q;
      pix_idx_d       = pix_idx_q;
      latch_cnt_d     = latch_cnt_q;
      pix_rd          = 1'b0;
      pix_addr        = pix_idx_q;

      if (prefetch_pend_q) begin
         hold_d = pix_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_FETCH;
               fetch_wait_d = 1'b0;
               pix_idx_d    = '0;
            end
         end
         // Two cycles: strobe the read, then capture the returned pixel.
         ST_FETCH: begin
            if (!fetch_wait_q) begin
               pix_rd       = 1'b1;
               pix_addr     = '0;
               fetch_wait_d = 1'b1;
            end else begin
               shift_d      = pix_data;
               bit_d        = '0;
               fetch_wait_d = 1'b0;
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            // Next pixel is fetched at the start of the final bit so it is ready a full slot early.
            if ((bit_q == LAST_BIT) && tmr_first && !last_pix) begin
               pix_rd          = 1'b1;
               pix_addr        = pix_idx_q + 1'b1;
               prefetch_pend_d = 1'b1;
            end
            if (tmr_last) begin
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (last_pix) begin
                     state_d     = ST_LATCH;
                     latch_cnt_d = '0;
                  end else begin
                     shift_d   = hold_q;
                     pix_idx_d = pix_idx_q + 1'b1;
                  end
               end else begin
                  shift_d = {shift_q[22:0], 1'b0};
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
         ST_LATCH: begin
            if (latch_cnt_q == LAST_LATCH) begin
               state_d     = ST_IDLE;
               done_d      = 1'b1;
               latch_cnt_d = '0;
               pix_idx_d   = '0;
            end else begin
               latch_cnt_d = latch_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= ST_IDLE;
         fetch_wait_q    <= 1'b0;
         prefetch_pend_q <= 1'b0;
         done_q          <= 1'b0;
         shift_q         <= '0;
         hold_q          <= '0;
         bit_q           <= '0;
         pix_idx_q       <= '0;
         latch_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         fetch_wait_q    <= fetch_wait_d;
         prefetch_pend_q <= prefetch_pend_d;
         done_q          <= done_d;
         shift_q         <= shift_d;
         hold_q          <= hold_d;
         bit_q           <= bit_d;
         pix_idx_q       <= pix_idx_d;
         latch_cnt_q     <= latch_cnt_d;
      end
   end

endmodule

// File: tb/tb_led_strip_controller.sv
// tb/tb_led_strip_controller.sv - self-checking bench for led_strip_controller (2-pixel and 64-pixel strips)
module tb_led_strip_controller;

   localparam int T0H     = 10;
   localparam int T1H     = 20;
   localparam int TBIT    = 31;
   localparam int TRES    = 1250;
   localparam int TRES64  = 100;
   localparam int PIX_CYC = 24 * TBIT;
   localparam int FRAME2  = 2 * PIX_CYC + TRES;
   localparam int FRAME64 = 64 * PIX_CYC + TRES64;

   typedef struct {
      logic [23:0] p0;
      logic [23:0] p1;
      int          hi_cycles;
   } vec_t;

   logic        clk, rstn;
   logic        start, busy, done, pix_rd, dout;
   logic [0:0]  pix_addr;
   logic [23:0] pix_data;
   logic        start64, busy64, done64, pix_rd64, dout64;
   logic [5:0]  pix_addr64;
   logic [23:0] pix_data64;

   logic [23:0] mem2 [2];
   logic [23:0] mem64 [64];
   int          rdq2[$];
   int          rdq64[$];
   logic        pend2, pend64;
   logic [0:0]  paddr2;
   logic [5:0]  paddr64;

   int n_pass = 0;
   int n_total = 0;

   led_strip_controller #(.N_LEDS(2), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES)) dut (
      .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
      .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data), .dout(dout)
   );

   led_strip_controller #(.N_LEDS(64), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES64)) dut64 (
      .clk(clk), .rstn(rstn), .start(start64), .busy(busy64), .done(done64),
      .pix_rd(pix_rd64), .pix_addr(pix_addr64), .pix_data(pix_data64), .dout(dout64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pixel memories: data appears for exactly the cycle after the read strobe, garbage otherwise.
   always @(negedge clk) begin
      pend2  = pix_rd;
      paddr2 = pix_addr;
      if (pix_rd) rdq2.push_back(int'(pix_addr));
      pend64  = pix_rd64;
      paddr64 = pix_addr64;
      if (pix_rd64) rdq64.push_back(int'(pix_addr64));
   end

   always @(posedge clk) begin
      #1;
      pix_data   = pend2 ? mem2[paddr2] : 24'($urandom);
      pix_data64 = pend64 ? mem64[paddr64] : 24'($urandom);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference waveform: offset within a pixel slot -> expected line level.
   function automatic logic wave(input logic [23:0] pixel, input int off);
      int b, c;
      b = 23 - off / TBIT;
      c = off % TBIT;
      return (c < (pixel[b] ? T1H : T0H)) ? 1'b1 : 1'b0;
   endfunction

   task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int exp_hi,
                            input bit chained, input bit inject, input bit chain_next, input int rst_at);
      int   errs, hi, dones, busy_errs, idle_errs;
      logic exp_d;
      mem2[0] = p0;
      mem2[1] = p1;
      rdq2.delete();
      if (!chained) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("lat_pix_rd", 32'(pix_rd), 32'd1);
      chk("lat_pix_addr", 32'(pix_addr), 32'd0);
      @(posedge clk); #1;
      chk("lat_dout_low", 32'(dout), 32'd0);
      errs = 0; hi = 0; dones = 0; busy_errs = 0;
      for (int j = 0; j < FRAME2; j++) begin
         @(posedge clk); #1;
         if (j < 2 * PIX_CYC) exp_d = wave(mem2[j / PIX_CYC], j % PIX_CYC);
         else exp_d = 1'b0;
         if (dout !== exp_d) errs++;
         if (dout === 1'b1) hi++;
         if (done !== 1'b0) dones++;
         if (busy !== 1'b1) busy_errs++;
         if (j == rst_at) begin
            chk("pre_rst_wave", 32'(errs), 32'd0);
            #2 rstn = 1'b0;
            #1;
            chk("rst_async_dout", 32'(dout), 32'd0);
            chk("rst_async_busy", 32'(busy), 32'd0);
            chk("rst_async_rd", 32'(pix_rd), 32'd0);
            @(posedge clk); #2;
            rstn = 1'b1;
            idle_errs = 0;
            for (int k = 0; k < 40; k++) begin
               @(posedge clk); #1;
               if (busy !== 1'b0 || dout !== 1'b0 || pix_rd !== 1'b0 || done !== 1'b0) idle_errs++;
            end
            chk("rst_stays_idle", 32'(idle_errs), 32'd0);
            return;
         end
         start = (inject && (j == 100 || j == FRAME2 - 300)) ? 1'b1 : 1'b0;
      end
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy_low", 32'(busy), 32'd0);
      chk("waveform", 32'(errs), 32'd0);
      chk("high_cycles", 32'(hi), 32'(exp_hi));
      chk("done_early", 32'(dones), 32'd0);
      chk("busy_in_frame", 32'(busy_errs), 32'd0);
      chk("rd_count", 32'(rdq2.size()), 32'd2);
      if (rdq2.size() == 2) begin
         chk("rd_addr0", 32'(rdq2[0]), 32'd0);
         chk("rd_addr1", 32'(rdq2[1]), 32'd1);
      end
      if (chain_next) begin
         start = 1'b1;
      end else begin
         @(posedge clk); #1;
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("no_restart", 32'(busy), 32'd0);
      end
   endtask

   function automatic int hi_of(input logic [23:0] p0, input logic [23:0] p1);
      int ones;
      ones = $countones({p0, p1});
      return ones * T1H + (48 - ones) * T0H;
   endfunction

   initial begin
      vec_t        tbl [5];
      logic [23:0] ra, rb;
      int          errs, busy_errs, dones, seq_errs;
      logic        exp_d;

      tbl[0] = '{24'hFF0000, 24'h000001, 570};
      tbl[1] = '{24'h000000, 24'h000000, 480};
      tbl[2] = '{24'hFFFFFF, 24'hFFFFFF, 960};
      tbl[3] = '{24'hAAAAAA, 24'h555555, 720};
      tbl[4] = '{24'h800000, 24'h000001, 500};

      rstn = 1'b0; start = 1'b0; start64 = 1'b0;
      pix_data = '0; pix_data64 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_pix_rd", 32'(pix_rd), 32'd0);
      chk("reset_pix_addr", 32'(pix_addr), 32'd0);
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_after_reset", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) run_frame(tbl[i].p0, tbl[i].p1, tbl[i].hi_cycles, 1'b0, 1'b0, 1'b0, -1);

      // Start pulses in SEND and LATCH must be ignored.
      run_frame(24'hFF0000, 24'h000001, 570, 1'b0, 1'b1, 1'b0, -1);

      // Back-to-back frames with start held in the done cycle.
      ra = 24'($urandom); rb = 24'($urandom);
      run_frame(24'hAAAAAA, 24'h555555, 720, 1'b0, 1'b0, 1'b1, -1);
      run_frame(ra, rb, hi_of(ra, rb), 1'b1, 1'b0, 1'b0, -1);

      for (int i = 0; i < 2; i++) begin
         ra = 24'($urandom); rb = 24'($urandom);
         run_frame(ra, rb, hi_of(ra, rb), 1'b0, 1'b0, 1'b0, -1);
      end

      // Reset during a high phase of pixel 1, then a normal frame.
      run_frame(24'hFF0000, 24'h000001, 570, 1'b0, 1'b0, 1'b0, PIX_CYC + 3);
      run_frame(24'h123456, 24'h89ABCD, hi_of(24'h123456, 24'h89ABCD), 1'b0, 1'b0, 1'b0, -1);

      // Full 64-pixel strip.
      for (int i = 0; i < 64; i++) mem64[i] = 24'($urandom);
      rdq64.delete();
      start64 = 1'b1;
      @(posedge clk); #1;
      start64 = 1'b0;
      chk("s64_lat_rd", 32'(pix_rd64), 32'd1);
      chk("s64_lat_addr", 32'(pix_addr64), 32'd0);
      @(posedge clk); #1;
      chk("s64_lat_dout", 32'(dout64), 32'd0);
      errs = 0; busy_errs = 0; dones = 0;
      for (int j = 0; j < FRAME64; j++) begin
         @(posedge clk); #1;
         if (j < 64 * PIX_CYC) exp_d = wave(mem64[j / PIX_CYC], j % PIX_CYC);
         else exp_d = 1'b0;
         if (dout64 !== exp_d) errs++;
         if (busy64 !== 1'b1) busy_errs++;
         if (done64 !== 1'b0) dones++;
      end
      @(posedge clk); #1;
      chk("s64_done", 32'(done64), 32'd1);
      chk("s64_busy_low", 32'(busy64), 32'd0);
      chk("s64_waveform", 32'(errs), 32'd0);
      chk("s64_busy_in_frame", 32'(busy_errs), 32'd0);
      chk("s64_done_early", 32'(dones), 32'd0);
      chk("s64_rd_count", 32'(rdq64.size()), 32'd64);
      seq_errs = 0;
      foreach (rdq64[i]) if (rdq64[i] != i) seq_errs++;
      chk("s64_addr_seq", 32'(seq_errs), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
